// File: rtl/reg_file_pkg.sv
// Shared constants and flattened-bus slice helpers for the register file.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int ZERO_ADDR      = 0;

  // LSB of port k's field in a flattened bus whose fields are width bits wide.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on a tie.
// Latency: busy_vector updates one edge after issue/writeback; no backpressure.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_enable,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  output logic [DEPTH-1:0]      busy_vector,
  output logic                  any_busy
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] keep_mask;

  always_comb begin
    set_vec   = '0;
    clr_vec   = '0;
    keep_mask = '1;
    if (issue_enable) set_vec[issue_address] = 1'b1;
    if (write_enable) clr_vec[write_address] = 1'b1;
    if (ZERO_REG != 0) keep_mask[ZERO_ADDR] = 1'b0;
  end

  // A new producer supersedes a same-cycle writeback, so set is OR-ed last.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_vector <= '0;
    end else begin
      busy_vector <= ((busy_vector & ~clr_vec) | set_vec) & keep_mask;
    end
  end

  assign any_busy = |busy_vector;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-to-read bypass, optional zero register and busy scoreboard.
// Latency: reads combinational, writes/scoreboard land on the next edge; no backpressure.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
  output logic [NUM_READ-1:0]              read_busy,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             issue_enable,
  input  logic [ADDR_WIDTH-1:0]            issue_address,
  output logic [(1<<ADDR_WIDTH)-1:0]       busy_vector,
  output logic                             any_busy
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam bit BYP_EN  = (BYPASS != 0);
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;

  assign wr_ok = write_enable &&
                 !(ZERO_EN && (write_address == ADDR_WIDTH'(ZERO_ADDR)));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[write_address] <= write_data;
    end
  end

  reg_scoreboard #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .issue_enable  (issue_enable),
    .issue_address (issue_address),
    .write_enable  (write_enable),
    .write_address (write_address),
    .busy_vector   (busy_vector),
    .any_busy      (any_busy)
  );

  // Zero-register forcing takes priority over bypass for address 0.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    logic                  is_zero;

    assign addr    = read_address[slice_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
    assign hit     = BYP_EN && write_enable && (write_address == addr);
    assign is_zero = ZERO_EN && (addr == ADDR_WIDTH'(ZERO_ADDR));

    assign read_data[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      is_zero ? '0 : (hit ? write_data : mem[addr]);
    assign read_busy[k] = !is_zero && !hit && busy_vector[addr];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: instance a = defaults (bypass, no zero reg, 2 ports); instance b = no bypass, zero reg, 4 ports.
module tb_reg_file_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic [5:0]  a_raddr = '0;
  logic [31:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_we = 1'b0;
  logic [2:0]  a_wa = '0;
  logic [15:0] a_wd = '0;
  logic        a_ie = 1'b0;
  logic [2:0]  a_ia = '0;
  logic [7:0]  a_bv;
  logic        a_any;

  logic [11:0] b_raddr = '0;
  logic [63:0] b_rdata;
  logic [3:0]  b_rbusy;
  logic        b_we = 1'b0;
  logic [2:0]  b_wa = '0;
  logic [15:0] b_wd = '0;
  logic        b_ie = 1'b0;
  logic [2:0]  b_ia = '0;
  logic [7:0]  b_bv;
  logic        b_any;

  int checks = 0;
  int errors = 0;

  always #10 clock = ~clock;

  reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(2), .BYPASS(1), .ZERO_REG(0)) u_a (
    .clock(clock), .reset(reset),
    .read_address(a_raddr), .read_data(a_rdata), .read_busy(a_rbusy),
    .write_enable(a_we), .write_address(a_wa), .write_data(a_wd),
    .issue_enable(a_ie), .issue_address(a_ia),
    .busy_vector(a_bv), .any_busy(a_any)
  );

  reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clock(clock), .reset(reset),
    .read_address(b_raddr), .read_data(b_rdata), .read_busy(b_rbusy),
    .write_enable(b_we), .write_address(b_wa), .write_data(b_wd),
    .issue_enable(b_ie), .issue_address(b_ia),
    .busy_vector(b_bv), .any_busy(b_any)
  );

  function automatic logic [15:0] a_rd(input int k);
    return a_rdata[k*16 +: 16];
  endfunction

  function automatic logic [15:0] b_rd(input int k);
    return b_rdata[k*16 +: 16];
  endfunction

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_we = 1'b0; a_ie = 1'b0;
    b_we = 1'b0; b_ie = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_we = 1'b1; a_wa = 3'(i); a_wd = 16'($urandom_range(1, 16'hFFFF));
      a_ie = 1'b1; a_ia = 3'(i);
      b_we = 1'b1; b_wa = 3'(i); b_wd = 16'($urandom_range(1, 16'hFFFF));
      b_ie = 1'b1; b_ia = 3'(i);
      cyc();
    end
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_raddr = {3'(i), 3'(i)};
      b_raddr = {3'(i), 3'(i), 3'(i), 3'(i)};
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_rd(k) !== 16'h0000 || a_rbusy[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_a addr %0d port %0d: data %h busy %b, want 0000 0", i, k, a_rd(k), a_rbusy[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (b_rd(k) !== 16'h0000 || b_rbusy[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_b addr %0d port %0d: data %h busy %b, want 0000 0", i, k, b_rd(k), b_rbusy[k]);
        end
      end
    end
    checks++;
    if (a_bv !== 8'h00 || a_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_busy: bv %h any %b, want 00 0", a_bv, a_any);
    end
    checks++;
    if (b_bv !== 8'h00 || b_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_b_busy: bv %h any %b, want 00 0", b_bv, b_any);
    end
  endtask

  task automatic test_bypass();
    a_we = 1'b1; a_wa = 3'd3; a_wd = 16'hBEEF; a_raddr = {3'd3, 3'd3};
    b_we = 1'b1; b_wa = 3'd3; b_wd = 16'hBEEF; b_raddr = {3'd0, 3'd0, 3'd0, 3'd3};
    #1;
    checks++;
    if (a_rd(0) !== 16'hBEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h want beef", a_rd(0));
    end
    checks++;
    if (b_rd(0) !== 16'h0000) begin
      errors++;
      $display("FAIL nobypass_same_cycle: got %h want 0000", b_rd(0));
    end
    cyc();
    idle();
    #1;
    checks++;
    if (a_rd(0) !== 16'hBEEF || a_rd(1) !== 16'hBEEF) begin
      errors++;
      $display("FAIL bypass_after_edge: got %h %h want beef beef", a_rd(0), a_rd(1));
    end
    checks++;
    if (b_rd(0) !== 16'hBEEF) begin
      errors++;
      $display("FAIL nobypass_after_edge: got %h want beef", b_rd(0));
    end
  endtask

  task automatic test_scoreboard();
    a_ie = 1'b1; a_ia = 3'd5; a_raddr = {3'd0, 3'd5};
    b_ie = 1'b1; b_ia = 3'd5; b_raddr = {3'd0, 3'd0, 3'd0, 3'd5};
    cyc();
    idle();
    #1;
    checks++;
    if (a_bv !== 8'h20 || a_any !== 1'b1 || a_rbusy[0] !== 1'b1) begin
      errors++;
      $display("FAIL issue_a: bv %h any %b rbusy %b, want 20 1 1", a_bv, a_any, a_rbusy[0]);
    end
    checks++;
    if (b_bv !== 8'h20 || b_any !== 1'b1 || b_rbusy[0] !== 1'b1) begin
      errors++;
      $display("FAIL issue_b: bv %h any %b rbusy %b, want 20 1 1", b_bv, b_any, b_rbusy[0]);
    end
    a_we = 1'b1; a_wa = 3'd5; a_wd = 16'h5555;
    b_we = 1'b1; b_wa = 3'd5; b_wd = 16'h5555;
    #1;
    checks++;
    if (a_rbusy[0] !== 1'b0 || a_bv !== 8'h20) begin
      errors++;
      $display("FAIL writeback_bypass_a: rbusy %b bv %h, want 0 20", a_rbusy[0], a_bv);
    end
    checks++;
    if (b_rbusy[0] !== 1'b1) begin
      errors++;
      $display("FAIL writeback_nobypass_b: rbusy %b, want 1", b_rbusy[0]);
    end
    cyc();
    idle();
    #1;
    checks++;
    if (a_bv !== 8'h00 || a_any !== 1'b0 || a_rbusy[0] !== 1'b0 || a_rd(0) !== 16'h5555) begin
      errors++;
      $display("FAIL cleared_a: bv %h any %b rbusy %b data %h, want 00 0 0 5555", a_bv, a_any, a_rbusy[0], a_rd(0));
    end
    checks++;
    if (b_bv !== 8'h00 || b_rbusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL cleared_b: bv %h rbusy %b, want 00 0", b_bv, b_rbusy[0]);
    end
  endtask

  task automatic test_issue_and_write();
    a_ie = 1'b1; a_ia = 3'd2; a_we = 1'b1; a_wa = 3'd2; a_wd = 16'h2222;
    a_raddr = {3'd2, 3'd0};
    cyc();
    idle();
    #1;
    checks++;
    if (a_bv !== 8'h04 || a_rd(1) !== 16'h2222 || a_rbusy[1] !== 1'b1) begin
      errors++;
      $display("FAIL issue_wins: bv %h data %h rbusy %b, want 04 2222 1", a_bv, a_rd(1), a_rbusy[1]);
    end
    a_ie = 1'b1; a_ia = 3'd2;
    cyc();
    idle();
    #1;
    checks++;
    if (a_bv !== 8'h04) begin
      errors++;
      $display("FAIL reissue_busy: bv %h, want 04", a_bv);
    end
    a_we = 1'b1; a_wa = 3'd2; a_wd = 16'h2223;
    cyc();
    idle();
    #1;
    checks++;
    if (a_bv !== 8'h00 || a_rd(1) !== 16'h2223) begin
      errors++;
      $display("FAIL writeback_clear: bv %h data %h, want 00 2223", a_bv, a_rd(1));
    end
  endtask

  task automatic test_zero_reg();
    a_we = 1'b1; a_wa = 3'd0; a_wd = 16'h1234; a_ie = 1'b1; a_ia = 3'd0; a_raddr = 6'd0;
    b_we = 1'b1; b_wa = 3'd0; b_wd = 16'h1234; b_ie = 1'b1; b_ia = 3'd0; b_raddr = 12'd0;
    #1;
    checks++;
    if (b_rd(0) !== 16'h0000 || b_rbusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_same_cycle: data %h busy %b, want 0000 0", b_rd(0), b_rbusy[0]);
    end
    cyc();
    idle();
    #1;
    checks++;
    if (b_rd(0) !== 16'h0000 || b_rbusy[0] !== 1'b0 || b_bv !== 8'h00 || b_any !== 1'b0) begin
      errors++;
      $display("FAIL zero_after_edge: data %h busy %b bv %h any %b, want 0000 0 00 0", b_rd(0), b_rbusy[0], b_bv, b_any);
    end
    checks++;
    if (a_rd(0) !== 16'h1234 || a_bv !== 8'h01 || a_rbusy[0] !== 1'b1) begin
      errors++;
      $display("FAIL nonzero_entry0: data %h bv %h busy %b, want 1234 01 1", a_rd(0), a_bv, a_rbusy[0]);
    end
    a_we = 1'b1; a_wa = 3'd0; a_wd = 16'h1234;
    cyc();
    idle();
  endtask

  task automatic test_four_ports();
    b_we = 1'b1; b_wa = 3'd3; b_wd = 16'h3C3C; cyc();
    b_wa = 3'd5; b_wd = 16'h5A5A; cyc();
    b_wa = 3'd6; b_wd = 16'h6969; cyc();
    b_wa = 3'd7; b_wd = 16'h7E7E; b_ie = 1'b1; b_ia = 3'd6; cyc();
    idle();
    b_raddr = {3'd7, 3'd6, 3'd5, 3'd3};
    #1;
    checks++;
    if (b_rdata !== {16'h7E7E, 16'h6969, 16'h5A5A, 16'h3C3C} || b_rbusy !== 4'b0100) begin
      errors++;
      $display("FAIL four_ports_distinct: data %h busy %b, want 7e7e69695a5a3c3c 0100", b_rdata, b_rbusy);
    end
    b_raddr = {3'd5, 3'd0, 3'd3, 3'd3};
    #1;
    checks++;
    if (b_rdata !== {16'h5A5A, 16'h0000, 16'h3C3C, 16'h3C3C} || b_rbusy !== 4'b0000) begin
      errors++;
      $display("FAIL four_ports_shared: data %h busy %b, want 5a5a00003c3c3c3c 0000", b_rdata, b_rbusy);
    end
  endtask

  task automatic test_reset_mid();
    a_we = 1'b1; a_wa = 3'd1; a_wd = 16'h1111; a_ie = 1'b1; a_ia = 3'd1;
    b_we = 1'b1; b_wa = 3'd1; b_wd = 16'h1111; b_ie = 1'b1; b_ia = 3'd1;
    cyc();
    a_wa = 3'd4; a_wd = 16'h4444; a_ia = 3'd4;
    b_wa = 3'd4; b_wd = 16'h4444; b_ia = 3'd4;
    cyc();
    idle();
    a_raddr = {3'd1, 3'd4};
    b_raddr = {3'd0, 3'd0, 3'd1, 3'd4};
    #1;
    checks++;
    if (a_bv !== 8'h12 || a_rd(0) !== 16'h4444 || a_rd(1) !== 16'h1111) begin
      errors++;
      $display("FAIL premid_a: bv %h data %h %h, want 12 4444 1111", a_bv, a_rd(0), a_rd(1));
    end
    checks++;
    if (b_bv !== 8'h52 || b_rd(0) !== 16'h4444) begin
      errors++;
      $display("FAIL premid_b: bv %h data %h, want 52 4444", b_bv, b_rd(0));
    end
    reset = 1'b1;
    a_we = 1'b1; a_wa = 3'd4; a_wd = 16'hAAAA; a_ie = 1'b1; a_ia = 3'd6;
    b_we = 1'b1; b_wa = 3'd4; b_wd = 16'hAAAA; b_ie = 1'b1; b_ia = 3'd6;
    cyc();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (a_rd(0) !== 16'h0000 || a_rd(1) !== 16'h0000 || a_bv !== 8'h00 || a_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_a: data %h %h bv %h any %b, want 0000 0000 00 0", a_rd(0), a_rd(1), a_bv, a_any);
    end
    checks++;
    if (b_rd(0) !== 16'h0000 || b_rd(1) !== 16'h0000 || b_bv !== 8'h00 || b_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_b: data %h %h bv %h any %b, want 0000 0000 00 0", b_rd(0), b_rd(1), b_bv, b_any);
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_bypass();
    test_scoreboard();
    test_issue_and_write();
    test_zero_reg();
    test_four_ports();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the 8x16 processor register file. Adds configurable width/depth/read-port count, write-to-read bypass, an optional hardwired zero register, synchronous reset of all entries, and a per-register busy scoreboard. The issue stage marks a destination busy. Writeback clears it. Decode reads data and busy state in the same cycle.

Parameters:
DATA_WIDTH, 16, register width in bits
ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries
NUM_READ, 2, number of independent combinational read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 0, 1 = entry 0 always reads 0, ignores writes, never busy

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
read_address  in  NUM_READ*ADDR_WIDTH  port k address at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
read_data  out  NUM_READ*DATA_WIDTH  port k data at bits [k*DATA_WIDTH +: DATA_WIDTH]
read_busy  out  NUM_READ  port k: addressed register has an outstanding producer
write_enable  in  1  writeback strobe
write_address  in  ADDR_WIDTH  writeback destination
write_data  in  DATA_WIDTH  writeback value
issue_enable  in  1  mark issue_address busy
issue_address  in  ADDR_WIDTH  destination of newly issued instruction
busy_vector  out  DEPTH  registered scoreboard, bit i = entry i busy
any_busy  out  1  OR-reduction of busy_vector

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset: on a clock edge with reset=1, all DEPTH entries go to 0, including the top entry, and busy_vector goes to 0. write_enable and issue_enable are ignored that cycle. Outputs follow from cleared state: read_data=0, read_busy=0, any_busy=0. This applies equally to reset asserted mid-operation.
- Write: on a clock edge with write_enable=1 and reset=0, entry[write_address] <= write_data. Latency 1 cycle to storage.
- Read: combinational from read_address, no clock latency. Every port is independent, and any ports may share an address.
- Bypass (BYPASS=1): if write_enable=1 and write_address equals port k's address, read_data[k] = write_data and read_busy[k] = 0. BYPASS=0: read_data shows the old stored value and read_busy shows the stored busy bit.
- Zero register (ZERO_REG=1): reads of address 0 return 0 and read_busy 0, including under bypass. Writes and issues to address 0 are dropped. busy_vector[0] is held at 0.
- Scoreboard update per edge (reset=0), evaluated per entry i:
  - set = issue_enable & issue_address==i
  - clr = write_enable & write_address==i
  - set=1 -> busy 1 (issue wins over a same-cycle clear: new producer supersedes)
  - clr=1 & set=0 -> busy 0
  - neither -> hold
- Issue to an already busy entry keeps it at 1. No counting and no error flag: a single outstanding producer per register is guaranteed upstream.
- A write to a non-busy entry is legal: the data updates and busy stays 0.
- busy_vector and any_busy are registered state, not bypassed. read_busy is the only bypassed busy view.
- Widths: addresses compare at full ADDR_WIDTH. No sign handling; data passes through unmodified.

Decomposition:
- Shared package reg_file_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - the read-port slice helpers (index arithmetic for the flattened buses);
  - a ZERO_ADDR constant.
- One sub-module, reg_scoreboard (DEPTH, ADDR_WIDTH, ZERO_REG), owns the busy bits, set/clear priority, and the any_busy reduction.
- Storage array, bypass muxes, and read ports stay in reg_file_sb.

Test Plan:
1. Reset then readback: assert reset 1 cycle after random writes to all 8 entries -> every port reads 0x0000 for addresses 0..7, busy_vector=8'h00, any_busy=0.
2. Write/read with bypass: write_enable=1, addr 3, data 0xBEEF, port0 addr 3, BYPASS=1 -> read_data port0=0xBEEF in the same cycle, and still 0xBEEF after the edge. With BYPASS=0, same cycle shows the old 0x0000, then 0xBEEF next cycle.
3. Scoreboard: issue addr 5 -> next cycle busy_vector=8'h20, any_busy=1, read_busy=1 on a port reading 5. Writeback addr 5 -> read_busy=0 that cycle (bypass), busy_vector=8'h00 next cycle.
4. Simultaneous issue and writeback to addr 2 -> busy_vector[2]=1 after the edge, and entry 2 holds the written data.
5. ZERO_REG=1: write 0x1234 to addr 0 and issue addr 0 -> read of addr 0 returns 0x0000, read_busy=0, busy_vector[0]=0.
6. Reset mid-operation: entries 1,4 busy and data nonzero, assert reset together with write_enable (addr 4, 0xAAAA) -> after the edge entry 4=0x0000 and busy_vector=8'h00. NUM_READ=4 variant: all four ports reading distinct addresses return the correct slices.
